serial_unit_arbiter: RTL

Round-robin arbiter and sequencer that shares one serial A/B/C multiply unit (and its sequencing FSM) between NUM_REQ requesters. It grants one requester and drives the requester-select mux. It then issues the load_b and start_a pulses to the unit FSM, tracks the serial C output (start_c/shift_c), and returns a per-requester done pulse before re-arbitrating.

---
 rtl/serial_unit_arbiter_if.sv | 27 ++
 rtl/serial_unit_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_unit_arbiter_if.sv
// Requester/unit-FSM signal bundle for serial_unit_arbiter.
// master: requesters plus the unit FSM; slave: the arbiter.
interface serial_unit_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned SEL_W   = 1
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               load_b;
  logic               start_a;
  logic               start_c;
  logic               shift_c;
  logic [NUM_REQ-1:0] done;
  logic               busy;
  logic               err;

  modport master (
    output req, start_c, shift_c,
    input  gnt, sel, load_b, start_a, done, busy, err
  );

  modport slave (
    input  req, start_c, shift_c,
    output gnt, sel, load_b, start_a, done, busy, err
  );
endinterface

// File: rtl/serial_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one serial A/B/C multiply unit among NUM_REQ requesters.
// Optional watchdog abort enabled by defining SERIAL_UNIT_ARB_TIMEOUT_EN.
module serial_unit_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned SEL_W          = 1,
  parameter int unsigned C_BITS         = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  serial_unit_arbiter_if.slave bus
);

  localparam int unsigned CNT_W     = $clog2(C_BITS + 1);
  localparam int unsigned SEL_W_EXP = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  generate
    if (SEL_W != SEL_W_EXP || NUM_REQ < 2 || NUM_REQ > 8 || C_BITS < 1 || TIMEOUT_CYCLES < 1)
    begin : g_bad_params
      $error("serial_unit_arbiter: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_B,
    ST_START_A,
    ST_WAIT_C,
    ST_DRAIN_C
  } state_e;

  state_e             state_q,   state_d;
  logic [NUM_REQ-1:0] gnt_q,     gnt_d;
  logic [SEL_W-1:0]   sel_q,     sel_d;
  logic [SEL_W-1:0]   last_q,    last_d;
  logic               load_b_q,  load_b_d;
  logic               start_a_q, start_a_d;
  logic [NUM_REQ-1:0] done_q,    done_d;
  logic               busy_q,    busy_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;

  logic               pick_valid;
  logic [SEL_W-1:0]   pick_idx;
  logic               finish;
  logic               abort;

`ifdef SERIAL_UNIT_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  // Requester index base+off, wrapped modulo NUM_REQ (off never exceeds NUM_REQ).
  function automatic logic [SEL_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
    int unsigned s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return SEL_W'(s);
  endfunction

  // First requesting index after the last winner, wrapping around.
  always_comb begin : rr_pick
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!pick_valid && bus.req[wrap_idx(32'(last_q), i)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(32'(last_q), i);
      end
    end
  end

  always_comb begin : fsm_comb
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    load_b_d  = 1'b0;
    start_a_d = 1'b0;
    done_d    = '0;
    finish    = 1'b0;
    abort     = 1'b0;
`ifdef SERIAL_UNIT_ARB_TIMEOUT_EN
    wd_d      = wd_q;
    err_d     = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        gnt_d  = '0;
        sel_d  = '0;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (pick_valid) begin
          gnt_d   = NUM_REQ'(1) << pick_idx;
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          last_d  = pick_idx;
          state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        load_b_d = 1'b1;
        state_d  = ST_START_A;
      end
      ST_START_A: begin
        start_a_d = 1'b1;
        state_d   = ST_WAIT_C;
      end
      ST_WAIT_C: begin
        if (bus.start_c) begin
          cnt_d = CNT_W'(1);
          if (C_BITS == 1) finish = 1'b1;
          else             state_d = ST_DRAIN_C;
        end
      end
      ST_DRAIN_C: begin
        if (bus.shift_c) begin
          if (cnt_q == CNT_W'(C_BITS - 1)) finish = 1'b1;
          else                             cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef SERIAL_UNIT_ARB_TIMEOUT_EN
    // Watchdog only runs while waiting on the unit's C output.
    if (state_q == ST_WAIT_C || state_q == ST_DRAIN_C) begin
      if (bus.start_c || bus.shift_c)           wd_d  = '0;
      else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) abort = 1'b1;
      else                                      wd_d  = wd_q + WD_W'(1);
    end else begin
      wd_d = '0;
    end
    if (abort) begin
      err_d = 1'b1;
      wd_d  = '0;
    end
`endif

    if (finish || abort) begin
      gnt_d   = '0;
      sel_d   = '0;
      busy_d  = 1'b0;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end
    if (finish) done_d = gnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin : fsm_regs
    if (!reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      last_q    <= SEL_W'(NUM_REQ - 1);
      load_b_q  <= 1'b0;
      start_a_q <= 1'b0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
`ifdef SERIAL_UNIT_ARB_TIMEOUT_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      load_b_q  <= load_b_d;
      start_a_q <= start_a_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
`ifdef SERIAL_UNIT_ARB_TIMEOUT_EN
      wd_q      <= wd_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.load_b  = load_b_q;
  assign bus.start_a = start_a_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
`ifdef SERIAL_UNIT_ARB_TIMEOUT_EN
  assign bus.err     = err_q;
`else
  assign bus.err     = 1'b0;
`endif

endmodule
